// File: rtl/rom_load_arb.sv
// Shared ROM BRAM port owner: HPS image download, CPU/AVG read arbitration,
// and CPU reset sequencing around image loads.
module rom_load_arb #(
  parameter int unsigned ROM_BYTES = 24576,
  parameter int unsigned AW        = 15,
  parameter int unsigned HOLD_CYC  = 1024
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [7:0]    cpu_rdata,
  input  logic          vg_req,
  input  logic [AW-1:0] vg_addr,
  output logic          vg_gnt,
  output logic          vg_rvalid,
  output logic [7:0]    vg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  output logic          cpu_reset,
  output logic          rom_err,
  output logic          loaded
);

  localparam int unsigned CW = $clog2(ROM_BYTES + 1);
  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [24:0]   ROM_END   = 25'(ROM_BYTES);
  localparam logic [CW-1:0] CNT_FULL  = CW'(ROM_BYTES);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [HW-1:0] hold_cnt;
  logic          pri_vg;
  logic          cpu_reset_q;
  logic [7:0]    cpu_rdata_q;
  logic [7:0]    vg_rdata_q;

  logic load_wr, in_range, wr_ok, wr_bad, start_load, arb_en, cpu_win, vg_win;

  // Download writes are only accepted once LOAD has been entered.
  assign load_wr    = (state == LOAD) && ioctl_download && ioctl_wr;
  assign in_range   = ioctl_addr < ROM_END;
  assign wr_ok      = load_wr && in_range;
  assign wr_bad     = load_wr && !in_range;
  assign start_load = ioctl_download && (state != LOAD);

  // Reads are served only in RUN, and not in the cycle a new download shows up.
  assign arb_en  = (state == RUN) && !ioctl_download;
  assign cpu_win = arb_en && cpu_req && (!vg_req || !pri_vg);
  assign vg_win  = arb_en && vg_req && (!cpu_req || pri_vg);

  assign cpu_gnt = cpu_win;
  assign vg_gnt  = vg_win;

  // A download arriving in RUN must hold the CPU in reset immediately.
  assign cpu_reset = cpu_reset_q || ((state == RUN) && ioctl_download);

  // Read data is live on the return cycle and held afterwards.
  assign cpu_rdata = cpu_rvalid ? mem_dout : cpu_rdata_q;
  assign vg_rdata  = vg_rvalid ? mem_dout : vg_rdata_q;

  // Shared BRAM port mux: download write, else granted reader.
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_din  = '0;
    if (wr_ok) begin
      mem_we   = 1'b1;
      mem_addr = ioctl_addr[AW-1:0];
      mem_din  = ioctl_dout;
    end else if (cpu_win) begin
      mem_addr = cpu_addr;
    end else if (vg_win) begin
      mem_addr = vg_addr;
    end
  end

  // Sequencer, byte counter, round-robin pointer and read-return registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      hold_cnt    <= '0;
      pri_vg      <= 1'b0;
      cpu_reset_q <= 1'b1;
      rom_err     <= 1'b0;
      loaded      <= 1'b0;
      cpu_rvalid  <= 1'b0;
      vg_rvalid   <= 1'b0;
      cpu_rdata_q <= '0;
      vg_rdata_q  <= '0;
    end else begin
      cpu_rvalid <= cpu_win;
      vg_rvalid  <= vg_win;
      if (cpu_rvalid) cpu_rdata_q <= mem_dout;
      if (vg_rvalid)  vg_rdata_q  <= mem_dout;

      if (cpu_win)     pri_vg <= 1'b1;
      else if (vg_win) pri_vg <= 1'b0;

      if (start_load) begin
        state       <= LOAD;
        byte_cnt    <= '0;
        rom_err     <= 1'b0;
        loaded      <= 1'b0;
        cpu_reset_q <= 1'b1;
      end else begin
        case (state)
          LOAD: begin
            if (!ioctl_download) begin
              if ((byte_cnt < CNT_FULL) || rom_err) begin
                state   <= IDLE;
                rom_err <= 1'b1;
              end else begin
                state    <= HOLD;
                hold_cnt <= '0;
              end
            end else begin
              if (wr_ok && (byte_cnt != CNT_MAX)) byte_cnt <= byte_cnt + 1'b1;
              if (wr_bad) rom_err <= 1'b1;
            end
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state       <= RUN;
              loaded      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_load_arb.sv
// Bench for rom_load_arb: BRAM model, byte-image reference, arbitration table
// and randomized read traffic checked against the read/grant rules.
module tb_rom_load_arb;

  localparam int unsigned ROM_BYTES = 24576;
  localparam int unsigned AW        = 15;
  localparam int unsigned HOLD_CYC  = 1024;

  logic          clk_sys, reset;
  logic          ioctl_download, ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          cpu_req, vg_req;
  logic [AW-1:0] cpu_addr, vg_addr;
  logic          cpu_gnt, cpu_rvalid, vg_gnt, vg_rvalid;
  logic [7:0]    cpu_rdata, vg_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_din, mem_dout;
  logic          cpu_reset, rom_err, loaded;

  rom_load_arb #(.ROM_BYTES(ROM_BYTES), .AW(AW), .HOLD_CYC(HOLD_CYC)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vg_req(vg_req), .vg_addr(vg_addr), .vg_gnt(vg_gnt),
    .vg_rvalid(vg_rvalid), .vg_rdata(vg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .cpu_reset(cpu_reset), .rom_err(rom_err), .loaded(loaded)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Single-port BRAM with registered read.
  logic [7:0] bram [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  logic [7:0] exp_img [0:ROM_BYTES-1];
  int vec_cnt = 0;
  int miss_cnt = 0;

  // Reference state: who was granted last, outstanding read returns, held data.
  bit            last_was_cpu = 1'b0;
  bit            rv_c = 1'b0, rv_v = 1'b0;
  logic [AW-1:0] rv_ca, rv_va;
  logic [7:0]    c_held = 8'h00, v_held = 8'h00;
  bit            c_pend = 1'b0, v_pend = 1'b0;
  logic [AW-1:0] c_a, v_a;

  typedef struct {
    logic          c;
    logic [AW-1:0] ca;
    logic          v;
    logic [AW-1:0] va;
    logic          gc;
    logic          gv;
  } arb_vec_t;
  arb_vec_t tv [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_vec(input int i, input bit c, input bit v, input bit gc, input bit gv);
    tv[i].c  = c;
    tv[i].ca = AW'(37 * i + 5);
    tv[i].v  = v;
    tv[i].va = AW'(1000 + 211 * i);
    tv[i].gc = gc;
    tv[i].gv = gv;
  endtask

  task automatic check_rvalid(input string tag);
    chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'(rv_c));
    if (rv_c) c_held = exp_img[int'(rv_ca)];
    chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(c_held));
    chk({tag, "_vg_rvalid"}, 32'(vg_rvalid), 32'(rv_v));
    if (rv_v) v_held = exp_img[int'(rv_va)];
    chk({tag, "_vg_rdata"}, 32'(vg_rdata), 32'(v_held));
  endtask

  task automatic start_download();
    tick();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    tick();
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    if (a < 25'(ROM_BYTES)) begin
      chk("wr_we", 32'(mem_we), 32'd1);
      chk("wr_addr", 32'(mem_addr), 32'(a[AW-1:0]));
      chk("wr_din", 32'(mem_din), 32'(d));
      exp_img[int'(a)] = d;
    end else begin
      chk("oor_we", 32'(mem_we), 32'd0);
    end
    chk("wr_no_gnt", 32'(cpu_gnt | vg_gnt), 32'd0);
  endtask

  task automatic load_image(input int n, input logic [7:0] xr);
    start_download();
    for (int i = 0; i < n; i++) write_byte(25'(i), 8'(i) ^ xr);
  endtask

  // Drop download after a complete image; checks the exact HOLD length.
  task automatic finish_good();
    int ones;
    int gnts;
    ones = 0;
    gnts = 0;
    tick();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    for (int k = 1; k <= int'(HOLD_CYC) + 1; k++) begin
      tick();
      @(negedge clk_sys);
      if (k <= int'(HOLD_CYC)) begin
        if (cpu_reset) ones++;
        if (cpu_gnt || vg_gnt) gnts++;
      end
    end
    chk("hold_len", 32'(ones), 32'(HOLD_CYC));
    chk("hold_no_gnt", 32'(gnts), 32'd0);
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("run_loaded", 32'(loaded), 32'd1);
    chk("run_rom_err", 32'(rom_err), 32'd0);
  endtask

  // Drop download after a bad image; CPU must stay in reset indefinitely.
  task automatic finish_short(input string tag);
    int z;
    z = 0;
    tick();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    for (int k = 0; k < int'(HOLD_CYC) + 64; k++) begin
      tick();
      @(negedge clk_sys);
      if (!cpu_reset || cpu_gnt || vg_gnt) z++;
    end
    chk({tag, "_reset_held"}, 32'(z), 32'd0);
    chk({tag, "_rom_err"}, 32'(rom_err), 32'd1);
    chk({tag, "_loaded"}, 32'(loaded), 32'd0);
  endtask

  task automatic rand_cycle(input bit allow_new);
    bit eg_c, eg_v;
    tick();
    cpu_req = c_pend;
    cpu_addr = c_a;
    vg_req = v_pend;
    vg_addr = v_a;
    ioctl_wr = ($urandom_range(0, 7) == 0);
    ioctl_addr = 25'($urandom_range(0, 32767));
    ioctl_dout = 8'($urandom);
    @(negedge clk_sys);
    eg_c = c_pend && (!v_pend || !last_was_cpu);
    eg_v = v_pend && (!c_pend || last_was_cpu);
    chk("rnd_cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
    chk("rnd_vg_gnt", 32'(vg_gnt), 32'(eg_v));
    chk("rnd_mem_we", 32'(mem_we), 32'd0);
    if (eg_c) chk("rnd_cpu_maddr", 32'(mem_addr), 32'(c_a));
    if (eg_v) chk("rnd_vg_maddr", 32'(mem_addr), 32'(v_a));
    check_rvalid("rnd");
    rv_c = eg_c; rv_ca = c_a;
    rv_v = eg_v; rv_va = v_a;
    if (eg_c) begin last_was_cpu = 1'b1; c_pend = 1'b0; end
    if (eg_v) begin last_was_cpu = 1'b0; v_pend = 1'b0; end
    if (allow_new) begin
      if (!c_pend && $urandom_range(0, 2) != 0) begin
        c_pend = 1'b1;
        c_a = AW'($urandom_range(0, ROM_BYTES - 1));
      end
      if (!v_pend && $urandom_range(0, 2) != 0) begin
        v_pend = 1'b1;
        v_a = AW'($urandom_range(0, ROM_BYTES - 1));
      end
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) rand_cycle(1'b1);
    for (int j = 0; j < 8; j++) if (c_pend || v_pend) rand_cycle(1'b0);
    chk("rnd_drained", 32'(c_pend || v_pend), 32'd0);
    tick();
    cpu_req = 1'b0;
    vg_req = 1'b0;
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    check_rvalid("rnd_end");
    chk("rnd_end_gnt", 32'(cpu_gnt | vg_gnt), 32'd0);
    rv_c = 1'b0;
    rv_v = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a_t4, b_t4;
    reset = 1'b1;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    cpu_req = 1'b1; cpu_addr = '0; vg_req = 1'b1; vg_addr = '0;
    c_a = '0; v_a = '0; rv_ca = '0; rv_va = '0;

    // Reset values, with both requesters asserting.
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_rom_err", 32'(rom_err), 32'd0);
    chk("rst_gnt", 32'(cpu_gnt | vg_gnt), 32'd0);
    chk("rst_rvalid", 32'(cpu_rvalid | vg_rvalid), 32'd0);
    chk("rst_rdata", 32'({cpu_rdata, vg_rdata}), 32'd0);
    chk("rst_mem", 32'({mem_we, mem_addr, mem_din}), 32'd0);
    tick();
    reset = 1'b0;
    cpu_req = 1'b0;
    vg_req = 1'b0;

    // Stray strobe with download low.
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'd10; ioctl_dout = 8'h77;
    @(negedge clk_sys);
    chk("stray_we", 32'(mem_we), 32'd0);
    tick();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("stray_rom_err", 32'(rom_err), 32'd0);
    chk("stray_cpu_reset", 32'(cpu_reset), 32'd1);

    // Short load of 100 bytes.
    load_image(100, 8'h11);
    finish_short("short");

    // Out-of-range write at the first address past the image.
    start_download();
    write_byte(25'h6000, 8'hEE);
    chk("reload_err_cleared", 32'(rom_err), 32'd0);
    write_byte(25'd3, 8'h33);
    chk("oor_sticky", 32'(rom_err), 32'd1);
    finish_short("oor");

    // Full load and release.
    load_image(ROM_BYTES, 8'h00);
    finish_good();

    // Arbitration table.
    set_vec(0, 1, 1, 1, 0);  set_vec(1, 1, 1, 0, 1);
    set_vec(2, 1, 1, 1, 0);  set_vec(3, 1, 1, 0, 1);
    set_vec(4, 1, 1, 1, 0);  set_vec(5, 1, 1, 0, 1);
    set_vec(6, 1, 0, 1, 0);  set_vec(7, 1, 0, 1, 0);
    set_vec(8, 0, 1, 0, 1);  set_vec(9, 0, 1, 0, 1);
    set_vec(10, 1, 1, 1, 0); set_vec(11, 0, 1, 0, 1);
    set_vec(12, 0, 0, 0, 0); set_vec(13, 1, 1, 1, 0);
    set_vec(14, 0, 1, 0, 1); set_vec(15, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      cpu_req = tv[i].c; cpu_addr = tv[i].ca;
      vg_req = tv[i].v;  vg_addr = tv[i].va;
      @(negedge clk_sys);
      chk($sformatf("tbl%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(tv[i].gc));
      chk($sformatf("tbl%0d_vg_gnt", i), 32'(vg_gnt), 32'(tv[i].gv));
      if (tv[i].gc) chk($sformatf("tbl%0d_maddr", i), 32'(mem_addr), 32'(tv[i].ca));
      if (tv[i].gv) chk($sformatf("tbl%0d_maddr", i), 32'(mem_addr), 32'(tv[i].va));
      check_rvalid($sformatf("tbl%0d", i));
      rv_c = tv[i].gc; rv_ca = tv[i].ca;
      rv_v = tv[i].gv; rv_va = tv[i].va;
      if (tv[i].gc) last_was_cpu = 1'b1;
      if (tv[i].gv) last_was_cpu = 1'b0;
    end

    run_random(1500);

    // Grant at T, download rises at T+1; then write beats a pending request.
    a_t4 = AW'(16'h1234);
    b_t4 = AW'(16'h0456);
    tick();
    cpu_req = 1'b1; cpu_addr = a_t4;
    @(negedge clk_sys);
    chk("t4_gnt", 32'(cpu_gnt), 32'd1);
    check_rvalid("t4a");
    rv_c = 1'b1; rv_ca = a_t4; last_was_cpu = 1'b1;
    tick();
    ioctl_download = 1'b1; cpu_addr = b_t4;
    @(negedge clk_sys);
    chk("t4_dl_no_gnt", 32'(cpu_gnt), 32'd0);
    chk("t4_dl_cpu_reset", 32'(cpu_reset), 32'd1);
    check_rvalid("t4b");
    rv_c = 1'b0;
    write_byte(25'(b_t4), 8'hC3);
    check_rvalid("t4c");
    tick();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    check_rvalid("t4d");
    chk("t4_loaded_clr", 32'(loaded), 32'd0);
    chk("t4_err_clr", 32'(rom_err), 32'd0);
    chk("t4_load_no_gnt", 32'(cpu_gnt), 32'd0);
    finish_short("t4");

    // Reset mid-load, request still pending throughout.
    load_image(5000, 8'h5A);
    tick();
    ioctl_wr = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_rst_loaded", 32'(loaded), 32'd0);
    @(negedge clk_sys);
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_gnt", 32'(cpu_gnt), 32'd0);
    last_was_cpu = 1'b0; c_held = 8'h00; v_held = 8'h00; rv_c = 1'b0; rv_v = 1'b0;
    check_rvalid("mid_rst");
    tick();
    reset = 1'b0;
    ioctl_download = 1'b0;
    load_image(ROM_BYTES, 8'hA5);
    finish_good();
    chk("pend_gnt", 32'(cpu_gnt), 32'd1);
    chk("pend_maddr", 32'(mem_addr), 32'(b_t4));
    rv_c = 1'b1; rv_ca = b_t4; last_was_cpu = 1'b1;
    c_pend = 1'b0; v_pend = 1'b0;

    run_random(600);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
